// File: rtl/meta_package.sv
// rtl/meta_package.sv - shared payload types for the PU queue
package meta_package;

  // One queue entry as stored in the payload BRAM
  typedef logic [31:0] pu_queue_payload_type;

endpackage

// File: rtl/pu_queue_rd_ctrl.sv
// rtl/pu_queue_rd_ctrl.sv - PU queue read side: BRAM prefetch into a 2-entry registered output buffer
// Optional feature macro: PU_QUEUE_RD_FLUSH_EN (adds the flush input)
module pu_queue_rd_ctrl
  import meta_package::*;
#(
  parameter int DEPTH_NBITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef PU_QUEUE_RD_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic [DEPTH_NBITS:0]   wr_ptr,
  output logic [DEPTH_NBITS-1:0] ram_raddr,
  input  pu_queue_payload_type   ram_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output pu_queue_payload_type   out_data,
  output logic [DEPTH_NBITS:0]   rd_ptr,
  output logic                   empty
);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  localparam logic [DEPTH_NBITS:0] PTR_ONE = {{DEPTH_NBITS{1'b0}}, 1'b1};

  buf_state_t           state;
  logic [DEPTH_NBITS:0] fptr;
  logic                 inflight;
  pu_queue_payload_type buf_tail;

  logic                 pop;
  logic [1:0]           buf_cnt;
  logic [2:0]           occ;
  logic                 issue;

  assign ram_raddr = fptr[DEPTH_NBITS-1:0];
  assign empty     = (wr_ptr == rd_ptr);

  // Issue a BRAM read only when the fetched-but-unpopped count stays within the 2-entry buffer
  always_comb begin
    pop     = out_valid & out_ready;
    buf_cnt = 2'd0;
    case (state)
      BUF_ONE: buf_cnt = 2'd1;
      BUF_TWO: buf_cnt = 2'd2;
      default: buf_cnt = 2'd0;
    endcase
    occ   = {1'b0, buf_cnt} + {2'b00, inflight};
    issue = (fptr != wr_ptr) && (occ < (3'd2 + {2'b00, pop}));
  end

  // Pointers, in-flight tracking and output buffer FSM; head entry drives out_data directly
  always_ff @(posedge clk) begin
    if (rst) begin
      fptr      <= '0;
      rd_ptr    <= '0;
      inflight  <= 1'b0;
      state     <= BUF_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      buf_tail  <= '0;
`ifdef PU_QUEUE_RD_FLUSH_EN
    end else if (flush) begin
      // Drop everything fetched so far and resynchronise both pointers to the writer
      fptr      <= wr_ptr;
      rd_ptr    <= wr_ptr;
      inflight  <= 1'b0;
      state     <= BUF_EMPTY;
      out_valid <= 1'b0;
`endif
    end else begin
      if (issue) begin
        fptr <= fptr + PTR_ONE;
      end
      // Read data returns the cycle after issue, so inflight doubles as the capture strobe
      inflight <= issue;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case (state)
        BUF_EMPTY: begin
          if (inflight) begin
            out_data  <= ram_rdata;
            state     <= BUF_ONE;
            out_valid <= 1'b1;
          end
        end
        BUF_ONE: begin
          if (inflight && pop) begin
            out_data <= ram_rdata;
          end else if (inflight) begin
            buf_tail <= ram_rdata;
            state    <= BUF_TWO;
          end else if (pop) begin
            state     <= BUF_EMPTY;
            out_valid <= 1'b0;
          end
        end
        BUF_TWO: begin
          // Capture without pop cannot occur here: issue is throttled to keep occupancy <= 2
          if (pop) begin
            out_data <= buf_tail;
            if (inflight) begin
              buf_tail <= ram_rdata;
            end else begin
              state <= BUF_ONE;
            end
          end
        end
        default: begin
          state     <= BUF_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_queue_rd_ctrl.sv
// tb/tb_pu_queue_rd_ctrl.sv - scoreboard bench for pu_queue_rd_ctrl with a behavioural payload BRAM
module tb_pu_queue_rd_ctrl;
  import meta_package::*;

  localparam int NB    = 4;
  localparam int DEPTH = 1 << NB;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NB:0]          wr_ptr = '0;
  logic [NB-1:0]        ram_raddr;
  pu_queue_payload_type ram_rdata;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  pu_queue_payload_type out_data;
  logic [NB:0]          rd_ptr;
  logic                 empty;
`ifdef PU_QUEUE_RD_FLUSH_EN
  logic                 flush = 1'b0;
`endif

  pu_queue_payload_type mem [DEPTH];
  pu_queue_payload_type sb[$];
  int errors = 0;
  int checks = 0;
  int seq    = 0;

  always #5 clk = ~clk;

  // Synchronous-read payload BRAM
  always @(posedge clk) ram_rdata <= mem[ram_raddr];

  pu_queue_rd_ctrl #(.DEPTH_NBITS(NB)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PU_QUEUE_RD_FLUSH_EN
    .flush     (flush),
`endif
    .wr_ptr    (wr_ptr),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rd_ptr    (rd_ptr),
    .empty     (empty)
  );

  // Writer: store payload, then expose it via wr_ptr; expected value goes to the scoreboard
  task automatic push_entry();
    pu_queue_payload_type d;
    d = 32'hC0DE_0000 + 32'(seq);
    seq++;
    mem[wr_ptr[NB-1:0]] = d;
    wr_ptr = wr_ptr + 5'd1;
    sb.push_back(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_ptr = '0;
    out_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (rd_ptr !== 5'd0) begin errors++; $display("FAIL reset_rd_ptr: got %0d want 0", rd_ptr); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (ram_raddr !== 4'd0) begin errors++; $display("FAIL reset_raddr: got %0d want 0", ram_raddr); end
  endtask

  task automatic test_single();
    pu_queue_payload_type exp;
    out_ready = 1'b1;
    push_entry();
    exp = sb[0];
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL single_data: got %h want %h", out_data, exp); end
    void'(sb.pop_front());
    @(negedge clk);
    checks++; if (rd_ptr !== 5'd1) begin errors++; $display("FAIL single_rd_ptr: got %0d want 1", rd_ptr); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", empty); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_after: got valid %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    pu_queue_payload_type exp;
    int pushed, got, first, gaps;
    pushed = 0; got = 0; first = -1; gaps = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 16; cyc++) begin
      if (pushed < 16) begin push_entry(); pushed++; end
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        got++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stream_extra: got %h want none", out_data); end
        else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin errors++; $display("FAIL stream_data: got %h want %h", out_data, exp); end
        end
      end else if (first >= 0) gaps++;
      @(negedge clk);
    end
    checks++; if (got !== 16) begin errors++; $display("FAIL stream_count: got %0d want 16", got); end
    checks++; if (first !== 2) begin errors++; $display("FAIL stream_latency: got %0d want 2", first); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b want 1", empty); end
  endtask

  task automatic test_backpressure();
    pu_queue_payload_type exp;
    logic [NB-1:0] start_addr;
    logic [NB:0]   start_rd;
    int bad;
    out_ready = 1'b0;
    start_addr = ram_raddr;
    start_rd = rd_ptr;
    for (int i = 0; i < 4; i++) begin push_entry(); @(negedge clk); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== sb[0]) begin
        errors++; $display("FAIL bp_hold: cycle %0d got valid %b data %h want 1 %h", i, out_valid, out_data, sb[0]);
      end
      @(negedge clk);
    end
    checks++; if (ram_raddr !== start_addr + 4'd2) begin errors++; $display("FAIL bp_reads: got raddr %0d want %0d", ram_raddr, start_addr + 4'd2); end
    checks++; if (rd_ptr !== start_rd) begin errors++; $display("FAIL bp_rd_ptr: got %0d want %0d", rd_ptr, start_rd); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
      if (out_valid && out_ready) begin
        checks++;
        exp = sb.pop_front();
        if (out_data !== exp) begin errors++; $display("FAIL bp_data: got %h want %h", out_data, exp); end
      end
      @(negedge clk);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left want 0", sb.size()); bad = 1; end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty: got %b want 1", empty); end
    if (bad != 0) sb.delete();
  endtask

  task automatic test_wrap();
    pu_queue_payload_type exp;
    logic [NB:0] used;
    int pushed;
    rst = 1'b1; wr_ptr = '0; out_ready = 1'b0; sb.delete();
    @(negedge clk);
    rst = 1'b0;
    pushed = 0;
    for (int cyc = 0; cyc < 2000 && (pushed < 40 || sb.size() > 0); cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      used = wr_ptr - rd_ptr;
      if (pushed < 40 && $urandom_range(0, 3) != 0 && used < 5'd16) begin push_entry(); pushed++; end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL wrap_extra: got %h want none", out_data); end
        else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin errors++; $display("FAIL wrap_data: got %h want %h", out_data, exp); end
        end
      end
      @(negedge clk);
    end
    checks++; if (sb.size() != 0 || pushed != 40) begin errors++; $display("FAIL wrap_done: got left %0d pushed %0d want 0 40", sb.size(), pushed); end
    checks++; if (rd_ptr !== 5'd8) begin errors++; $display("FAIL wrap_rd_ptr: got %0d want 8", rd_ptr); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
    out_ready = 1'b0;
    sb.delete();
  endtask

  task automatic test_full();
    pu_queue_payload_type exp;
    int got, gaps, first;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin push_entry(); @(negedge clk); end
    repeat (3) @(negedge clk);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL full_empty: got %b want 0", empty); end
    checks++; if (rd_ptr !== 5'd8) begin errors++; $display("FAIL full_rd_ptr: got %0d want 8", rd_ptr); end
    checks++; if (out_valid !== 1'b1 || out_data !== sb[0]) begin errors++; $display("FAIL full_head: got %b %h want 1 %h", out_valid, out_data, sb[0]); end
    out_ready = 1'b1;
    got = 0; gaps = 0; first = -1;
    for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        got++;
        checks++;
        exp = sb.pop_front();
        if (out_data !== exp) begin errors++; $display("FAIL full_data: got %h want %h", out_data, exp); end
      end else if (first >= 0) gaps++;
      @(negedge clk);
    end
    checks++; if (got !== 16 || gaps !== 0) begin errors++; $display("FAIL full_count: got %0d gaps %0d want 16 0", got, gaps); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_after_empty: got %b want 1", empty); end
    checks++; if (rd_ptr !== 5'd24) begin errors++; $display("FAIL full_after_rd_ptr: got %0d want 24", rd_ptr); end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    pu_queue_payload_type exp;
    int got;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin push_entry(); @(negedge clk); end
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1; wr_ptr = '0; sb.delete();
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    checks++; if (rd_ptr !== 5'd0) begin errors++; $display("FAIL rstmid_rd_ptr: got %0d want 0", rd_ptr); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b want 1", empty); end
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got valid %b want 0", out_valid); end
    push_entry();
    got = 0;
    for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
      if (out_valid && out_ready) begin
        got++;
        checks++;
        exp = sb.pop_front();
        if (out_data !== exp) begin errors++; $display("FAIL rstmid_data: got %h want %h", out_data, exp); end
      end
      @(negedge clk);
    end
    checks++; if (got !== 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", got); end
  endtask

`ifdef PU_QUEUE_RD_FLUSH_EN
  task automatic test_flush();
    pu_queue_payload_type exp;
    int got;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin push_entry(); @(negedge clk); end
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b1; sb.delete();
    @(negedge clk);
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (rd_ptr !== wr_ptr) begin errors++; $display("FAIL flush_rd_ptr: got %0d want %0d", rd_ptr, wr_ptr); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b want 1", empty); end
    push_entry();
    got = 0;
    for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
      if (out_valid && out_ready) begin
        got++;
        checks++;
        exp = sb.pop_front();
        if (out_data !== exp) begin errors++; $display("FAIL flush_data: got %h want %h", out_data, exp); end
      end
      @(negedge clk);
    end
    checks++; if (got !== 1) begin errors++; $display("FAIL flush_count: got %0d want 1", got); end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_wrap();
    test_full();
    test_reset_mid();
`ifdef PU_QUEUE_RD_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
